// File: rtl/ascon_perm_sequencer_if.sv
// Handshake bundle between the ASCON permutation sequencer, the mode controller,
// the external round counter and the permutation datapath.
interface ascon_perm_sequencer_if #(
  parameter int CTR_W = 5
);
  logic             perm_req;
  logic [3:0]       perm_rounds;
  logic [CTR_W-1:0] counter;
  logic             permutation_start;
  logic             permutation_ready;
  logic             round_en;
  logic [7:0]       round_const;
  logic             perm_busy;
  logic             perm_done;
  logic             perm_err;
  logic             sync_err;

  modport slave (
    input  perm_req, perm_rounds, counter,
    output permutation_start, permutation_ready, round_en, round_const,
           perm_busy, perm_done, perm_err, sync_err
  );

  modport master (
    output perm_req, perm_rounds, counter,
    input  permutation_start, permutation_ready, round_en, round_const,
           perm_busy, perm_done, perm_err, sync_err
  );
endinterface

// File: rtl/ascon_perm_sequencer.sv
// ASCON permutation sequencer: runs the round-counter handshake and emits per-round constants.
// Optional macro ASCON_PERM_SEQ_CHECK_EN adds a shadow counter that flags counter desync on sync_err.
module ascon_perm_sequencer #(
  parameter int MAX_ROUNDS = 12,
  parameter int CTR_W      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  ascon_perm_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] MAX_R = MAX_ROUNDS[3:0];

  logic [1:0]       r_state;
  logic [3:0]       r_rounds;
  logic             r_permErr;

  logic             w_legal;
  logic [CTR_W-1:0] w_roundsExt;
  logic             w_inRange;
  logic             w_lastOrPast;
  logic [3:0]       w_idx;
  logic             w_start;
  logic             w_done;
  logic             w_roundEn;

  assign w_legal      = (bus.perm_rounds != 4'd0) && (bus.perm_rounds <= MAX_R);
  assign w_roundsExt  = {{(CTR_W-4){1'b0}}, r_rounds};
  assign w_inRange    = bus.counter < w_roundsExt;
  // Also catches a corrupted counter already past the end, so the run still closes.
  assign w_lastOrPast = bus.counter >= (w_roundsExt - CTR_W'(1));
  // Short runs use the tail of the 12-entry table.
  assign w_idx        = MAX_R - r_rounds + bus.counter[3:0];

  assign w_start   = (r_state == S_RUN);
  assign w_done    = (r_state == S_DONE);
  assign w_roundEn = w_start && w_inRange;

  assign bus.permutation_start = w_start;
  assign bus.permutation_ready = w_done;
  assign bus.perm_done         = w_done;
  assign bus.perm_busy         = w_start || w_done;
  assign bus.round_en          = w_roundEn;
  assign bus.round_const       = w_roundEn ? {~w_idx, w_idx} : 8'h00;
  assign bus.perm_err          = r_permErr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rounds  <= 4'd0;
      r_permErr <= 1'b0;
    end else begin
      r_permErr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.perm_req) begin
            if (w_legal) begin
              r_rounds <= bus.perm_rounds;
              r_state  <= S_RUN;
            end else begin
              r_permErr <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_lastOrPast) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ASCON_PERM_SEQ_CHECK_EN
  logic [CTR_W-1:0] r_shadow;
  logic             r_syncErr;

  // Shadow follows the same clear/increment rule as the external round counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_syncErr <= 1'b0;
    end else begin
      if (w_done || !w_start) r_shadow <= '0;
      else                    r_shadow <= r_shadow + CTR_W'(1);
      if (w_start && (r_shadow != bus.counter)) r_syncErr <= 1'b1;
    end
  end

  assign bus.sync_err = r_syncErr;
`else
  assign bus.sync_err = 1'b0;
`endif

endmodule
